// File: rtl/store_rmw_unit.sv
// store_rmw_unit
//   Store path for a word-only data memory (no byte enables).
//   sw is written straight through. sh/sb read the old word, merge the new
//   half-word/byte lane and write the merged word back.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   start         request strobe, only looked at in IDLE
//   op            00 sw, 01 sh, 10 sb, 11 reserved
//   addr          byte address of the store
//   wdata         register value; low 8/16/32 bits are stored
//   mem_rdata     memory read data, valid RD_LAT cycles after the mem_re cycle
//   mem_addr      word address of the access (byte offset forced to 0)
//   mem_re        one-cycle read strobe (sh/sb only)
//   mem_we        one-cycle write strobe
//   mem_wdata     word to write, 0 whenever mem_we is low
//   busy          high in every state except IDLE
//   done          one-cycle completion pulse (coincides with mem_we)
//   err           one-cycle pulse for misaligned address or reserved op
module store_rmw_unit #(
    parameter int RD_LAT = 1            // memory read latency, 1..4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] LAT    = 3'(RD_LAT);
    localparam logic [1:0] OP_SW  = 2'b00;
    localparam logic [1:0] OP_SH  = 2'b01;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, ERR} state_t;

    state_t      state_reg, state_next;
    logic [1:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [31:0] old_q;
    logic [2:0]  cnt;

    logic        bad_req;
    logic [31:0] sb_word;
    logic [31:0] sh_word;
    logic [31:0] merged_word;

    // Reserved op, odd half-word address, or non-word-aligned word store.
    assign bad_req = (op == OP_RSV)
                   || ((op == OP_SH) && addr[0])
                   || ((op == OP_SW) && (addr[1:0] != 2'b00));

    // State and datapath registers. Outputs are decoded from state_reg, so an
    // asynchronous reset drops mem_re/mem_we in the same instant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            op_q      <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            old_q     <= '0;
            cnt       <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        addr_q <= addr;
                        data_q <= wdata;
                    end
                end
                READ: cnt <= LAT;
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        old_q <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (bad_req)           state_next = ERR;
                    else if (op == OP_SW)  state_next = WRITE;
                    else                   state_next = READ;
                end
            end
            READ:    state_next = WAIT;
            WAIT:    if (cnt == 3'd1) state_next = WRITE;
            WRITE:   state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Byte-lane merge: lane 0 is bits [7:0], lane 3 is bits [31:24].
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sb_lane
            assign sb_word[8*gi +: 8] = (addr_q[1:0] == 2'(gi)) ? data_q[7:0]
                                                                 : old_q[8*gi +: 8];
        end
        for (genvar gi = 0; gi < 2; gi++) begin : g_sh_lane
            assign sh_word[16*gi +: 16] = (addr_q[1] == 1'(gi)) ? data_q[15:0]
                                                                 : old_q[16*gi +: 16];
        end
    endgenerate

    always_comb begin
        merged_word = sb_word;
        if (op_q == OP_SW)      merged_word = data_q;
        else if (op_q == OP_SH) merged_word = sh_word;
    end

    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign busy      = (state_reg != IDLE);
    assign mem_re    = (state_reg == READ);
    assign mem_we    = (state_reg == WRITE);
    assign done      = (state_reg == WRITE);
    assign err       = (state_reg == ERR);
    assign mem_wdata = (state_reg == WRITE) ? merged_word : 32'd0;

endmodule

// File: tb/tb_store_rmw_unit.sv
module tb_store_rmw_unit;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;

    store_rmw_unit #(.RD_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .addr(addr),
        .wdata(wdata), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
        .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- word-only memory with LAT-cycle read pipeline ----------------
    logic [31:0] dmem [0:255];
    logic [31:0] pipe [0:LAT-1];
    assign mem_rdata = pipe[LAT-1];

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h13572468;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) dmem[i] = init_word(i);
        for (int i = 0; i < LAT; i++) pipe[i] = 32'hBAD0BAD0;
        forever begin
            @(posedge clk);
            for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
            pipe[0] <= mem_re ? dmem[mem_addr[9:2]] : 32'hBAD0BAD0;
            if (mem_we) dmem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    // ---------------- reference model: byte-addressed memory ----------------
    logic [7:0] ref_b [0:1023];

    typedef struct {
        logic [1:0]  op;
        bit          is_err;
        int          cycle;
        logic [31:0] addr;
        logic [31:0] data;
        int          n_re;
    } exp_t;
    exp_t q[$];

    task automatic push_exp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        bit   bad;
        int   nbytes;
        int   base;
        bad    = (o == 2'b11) || (o == 2'b01 && a[0]) || (o == 2'b00 && a[1:0] != 2'b00);
        base   = int'(a[9:0]) & ~3;
        e.op     = o;
        e.is_err = bad;
        e.addr   = {a[31:2], 2'b00};
        e.n_re   = (!bad && o != 2'b00) ? 1 : 0;
        e.cycle  = cyc + ((bad || o == 2'b00) ? 1 : LAT + 2);
        if (!bad) begin
            nbytes = (o == 2'b00) ? 4 : (o == 2'b01) ? 2 : 1;
            for (int k = 0; k < nbytes; k++) ref_b[int'(a[9:0]) + k] = d[8*k +: 8];
        end
        e.data = bad ? 32'd0 : {ref_b[base+3], ref_b[base+2], ref_b[base+1], ref_b[base]};
        q.push_back(e);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        int   re_cnt;
        exp_t e;
        re_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                re_cnt = 0;
            end else begin
                if (mem_re) re_cnt++;
                chk(!(mem_we && !done), "we_without_done", 32'(mem_we), 32'(done));
                chk(mem_we || mem_wdata == 32'd0, "wdata_idle_zero", mem_wdata, 32'd0);
                if (done || err) begin
                    if (q.size() == 0) begin
                        chk(1'b0, "unexpected_response", {30'd0, done, err}, 32'd0);
                    end else begin
                        e = q.pop_front();
                        $display("[%0t] txn op=%0d addr=%08h -> %s data=%08h", $time,
                                 e.op, e.addr, err ? "err" : "done", mem_wdata);
                        chk(err == e.is_err, "err_flag", 32'(err), 32'(e.is_err));
                        chk(done == !e.is_err, "done_flag", 32'(done), 32'(!e.is_err));
                        chk(cyc == e.cycle, "latency", 32'(cyc), 32'(e.cycle));
                        chk(re_cnt == e.n_re, "read_count", 32'(re_cnt), 32'(e.n_re));
                        if (!e.is_err) begin
                            chk(mem_we, "mem_we", 32'(mem_we), 32'd1);
                            chk(mem_addr == e.addr, "mem_addr", mem_addr, e.addr);
                            chk(mem_wdata == e.data, "mem_wdata", mem_wdata, e.data);
                        end else begin
                            chk(!mem_we, "err_no_write", 32'(mem_we), 32'd0);
                        end
                    end
                    re_cnt = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle(input bit noise);
        for (int k = 0; k < 64; k++) begin
            if (!busy) return;
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                op    = 2'($urandom);
                addr  = $urandom;
                wdata = $urandom;
            end
            @(negedge clk);
        end
        chk(1'b0, "idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] d);
        wait_idle(1'b1);
        push_exp(o, a, d);
        start = 1'b1; op = o; addr = a; wdata = d;
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); addr = $urandom; wdata = $urandom;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        bit          seen;
        for (int i = 0; i < 256; i++)
            for (int k = 0; k < 4; k++) ref_b[4*i + k] = init_word(i)[8*k +: 8];

        rst = 1'b1; start = 1'b0; op = 2'b00; addr = 32'd0; wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk(!busy, "reset_busy", 32'(busy), 32'd0);
        chk(!done && !err, "reset_done_err", {30'd0, done, err}, 32'd0);
        chk(!mem_re && !mem_we, "reset_strobes", {30'd0, mem_re, mem_we}, 32'd0);
        chk(mem_addr == 32'd0, "reset_mem_addr", mem_addr, 32'd0);
        chk(mem_wdata == 32'd0, "reset_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases from the test plan (memory preloaded via sw).
        do_op(2'b00, 32'h0000_0100, 32'hDEAD_BEEF);
        do_op(2'b00, 32'h0000_0100, 32'h1122_3344);
        do_op(2'b10, 32'h0000_0102, 32'hAABB_CCDD);   // -> 11DD3344
        do_op(2'b00, 32'h0000_0200, 32'h1122_3344);
        do_op(2'b01, 32'h0000_0202, 32'h0000_BEEF);   // -> BEEF3344
        do_op(2'b00, 32'h0000_0200, 32'h1122_3344);
        do_op(2'b01, 32'h0000_0200, 32'hFFFF_BEEF);   // -> 1122BEEF
        do_op(2'b01, 32'h0000_0203, 32'h1234_5678);   // misaligned sh
        do_op(2'b11, 32'h0000_0200, 32'h1234_5678);   // reserved op
        do_op(2'b00, 32'h0000_0101, 32'h1234_5678);   // misaligned sw
        do_op(2'b10, 32'h0000_0103, 32'h0000_0099);

        // start held high for a whole sb: exactly one transaction.
        wait_idle(1'b0);
        push_exp(2'b10, 32'h0000_0041, 32'h5566_7788);
        start = 1'b1; op = 2'b10; addr = 32'h0000_0041; wdata = 32'h5566_7788;
        seen = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
        end
        start = 1'b0;
        chk(seen, "hold_start_done", 32'(seen), 32'd1);
        do_op(2'b10, 32'h0000_0042, 32'h0000_00A5);   // issued cycle after done

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            if (ro == 2'b00 && $urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
            if (ro == 2'b01 && $urandom_range(0, 3) != 0) ra[0] = 1'b0;
            do_op(ro, ra, $urandom);
        end

        // Reset during WAIT of an sb: abort, nothing written.
        wait_idle(1'b0);
        start = 1'b1; op = 2'b10; addr = 32'h0000_0311; wdata = 32'h0000_00EE;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk(!mem_re && !mem_we, "abort_strobes", {30'd0, mem_re, mem_we}, 32'd0);
        chk(!busy, "abort_busy", 32'(busy), 32'd0);
        chk(mem_addr == 32'd0, "abort_mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_op(2'b00, 32'h0000_0020, 32'hCAFE_F00D);
        do_op(2'b10, 32'h0000_0312, 32'h0000_0077);   // same word: old value intact

        wait_idle(1'b0);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk(q.size() == 0, "pending_responses", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
